// File: rtl/frame_fetch_ctrl_if.sv
// Image RAM read port plus display-path pixel stream used by frame_fetch_ctrl.
interface frame_fetch_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sol;
  logic              out_eof;

  modport master (
    output mem_rd_en, mem_addr, out_data, out_valid, out_sol, out_eof,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_data, out_valid, out_sol, out_eof,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/frame_fetch_ctrl.sv
// Streams one frame of image RAM words to the display path through a 2-entry FIFO.
// Define FRAME_FETCH_LOOP_EN to restart the frame at address 0 after every out_eof transfer.
module frame_fetch_ctrl #(
  parameter int WORDS_PER_LINE  = 20,
  parameter int LINES_PER_FRAME = 10,
  parameter int ADDR_W          = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  frame_fetch_ctrl_if.master bus
);

  localparam int N  = WORDS_PER_LINE * LINES_PER_FRAME;
  localparam int CW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(WORDS_PER_LINE - 1);

  if (N < 1 || N > (1 << ADDR_W)) begin : g_frame_size_check
    $error("frame_fetch_ctrl: frame of %0d words does not fit ADDR_W=%0d", N, ADDR_W);
  end

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic              infl_q, infl_d;
  logic              infl_sol_q, infl_sol_d;
  logic              infl_eof_q, infl_eof_d;
  logic [1:0][31:0]  fdata_q, fdata_d;
  logic [1:0]        fsol_q, fsol_d;
  logic [1:0]        feof_q, feof_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  logic        issue, credit, fifo_empty, valid, xfer, eof_xfer, push, pop;
  logic [31:0] head_data;
  logic        head_sol, head_eof;

  // With the FIFO empty the returning RAM word is presented directly, which is
  // what gives 2-cycle start latency and one word per cycle with only 2 credits.
  always_comb begin
    fifo_empty = (cnt_q == 2'd0);
    valid      = !fifo_empty || infl_q;
    head_data  = fifo_empty ? bus.mem_rdata : fdata_q[rd_ptr_q];
    head_sol   = fifo_empty ? infl_sol_q    : fsol_q[rd_ptr_q];
    head_eof   = fifo_empty ? infl_eof_q    : feof_q[rd_ptr_q];
    xfer       = valid && bus.out_ready;
    eof_xfer   = xfer && head_eof;
    push       = infl_q && !(fifo_empty && bus.out_ready);
    pop        = xfer && !fifo_empty;
    credit     = (cnt_q + {1'b0, infl_q}) < 2'd2;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (issue && addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN: begin
        if (eof_xfer) begin
`ifdef FRAME_FETCH_LOOP_EN
          state_d = (issue && addr_q == LAST_ADDR) ? DRAIN : FETCH;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In loop mode the first read of the next frame goes out in the eof transfer cycle.
  always_comb begin
    issue = (state_q == FETCH) && credit;
`ifdef FRAME_FETCH_LOOP_EN
    if (state_q == DRAIN && eof_xfer && credit) issue = 1'b1;
`endif
    busy = (state_q != IDLE);
    done = done_q;
  end

  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? head_data : 32'd0;
  assign bus.out_sol   = valid && head_sol;
  assign bus.out_eof   = valid && head_eof;

  always_comb begin
    addr_d     = addr_q;
    col_d      = col_q;
    infl_d     = issue;
    infl_sol_d = infl_sol_q;
    infl_eof_d = infl_eof_q;
    if (issue) begin
      infl_sol_d = (col_q == '0);
      infl_eof_d = (addr_q == LAST_ADDR);
      addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      col_d      = (col_q == LAST_COL || addr_q == LAST_ADDR) ? '0 : col_q + CW'(1);
    end
    fdata_d = fdata_q;
    fsol_d  = fsol_q;
    feof_d  = feof_q;
    if (push) begin
      fdata_d[wr_ptr_q] = bus.mem_rdata;
      fsol_d[wr_ptr_q]  = infl_sol_q;
      feof_d[wr_ptr_q]  = infl_eof_q;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
    done_d   = eof_xfer;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      col_q      <= '0;
      infl_q     <= 1'b0;
      infl_sol_q <= 1'b0;
      infl_eof_q <= 1'b0;
      fdata_q    <= '0;
      fsol_q     <= '0;
      feof_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      col_q      <= col_d;
      infl_q     <= infl_d;
      infl_sol_q <= infl_sol_d;
      infl_eof_q <= infl_eof_d;
      fdata_q    <= fdata_d;
      fsol_q     <= fsol_d;
      feof_q     <= feof_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: doc/frame_fetch_ctrl.md
FRAME_FETCH_CTRL -- requirements
Module: frame_fetch_ctrl

Interface
REQ-001 Parameter WORDS_PER_LINE, default 20, 32-bit image words per display line.
REQ-002 Parameter LINES_PER_FRAME, default 10, lines per frame; frame size N = WORDS_PER_LINE*LINES_PER_FRAME (default 200).
REQ-003 Parameter ADDR_W, default 8, image RAM address width; N SHALL be <= 2^ADDR_W, else elaboration error.
REQ-004 clock  input  1  sole clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin streaming a frame.
REQ-007 mem_rd_en  output  1  image RAM read strobe.
REQ-008 mem_addr  output  ADDR_W  image RAM word address.
REQ-009 mem_rdata  input  32  RAM read data, valid exactly one cycle after mem_rd_en.
REQ-010 out_data  output  32  pixel word to display path.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  display path accepts word; transfer = out_valid & out_ready.
REQ-013 out_sol  output  1  qualifies out_data as first word of a line.
REQ-014 out_eof  output  1  qualifies out_data as last word of frame.
REQ-015 busy  output  1  high from start acceptance until last word transferred.
REQ-016 done  output  1  one-cycle pulse after frame completion.

Function
REQ-017 States: IDLE, FETCH (issuing reads), DRAIN (all N reads issued, words still buffered).
REQ-018 IDLE -> FETCH on start=1; start while busy SHALL be ignored.
REQ-019 Reads issue in address order 0..N-1, one per cycle max, mem_addr stable while mem_rd_en=1.
REQ-020 Returned words enter a 2-entry FIFO; a read SHALL issue only if (FIFO occupancy + in-flight reads) < 2, so no word is ever dropped.
REQ-021 First mem_rd_en SHALL occur the cycle after start is sampled; first out_valid the cycle after that (2-cycle start-to-valid latency with out_ready=1).
REQ-022 With out_ready held 1, one word SHALL transfer per cycle (full throughput).
REQ-023 While out_valid=1 and out_ready=0, out_data/out_sol/out_eof SHALL hold stable.
REQ-024 out_sol=1 for words whose index mod WORDS_PER_LINE = 0; out_eof=1 only for word N-1; both 0 when out_valid=0.
REQ-025 After issuing address N-1: FETCH -> DRAIN; no further reads; address counter returns to 0.
REQ-026 DRAIN -> IDLE on transfer of the out_eof word; done=1 the following cycle; busy falls the same cycle as done rises.
REQ-027 out_ready toggling arbitrarily SHALL never duplicate, drop or reorder words.

Reset
REQ-028 On reset_n=0, immediately: state IDLE, FIFO empty, in-flight read discarded, address/word counters 0.
REQ-029 Reset values: mem_rd_en 0, mem_addr 0, out_data 0, out_valid 0, out_sol 0, out_eof 0, busy 0, done 0.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse; next start begins again at address 0.

Configuration
REQ-031 Macro FRAME_FETCH_LOOP_EN: when defined, transfer of the out_eof word SHALL restart at address 0 with no gap beyond the FIFO credit rule, busy stays 1, done pulses once per frame, start is ignored after the first.
REQ-032 Without FRAME_FETCH_LOOP_EN: single-frame behaviour of REQ-026, new start required per frame.

Verification
REQ-033 Reset, start, out_ready=1 -> mem_addr 0..199 consecutive, 200 transfers matching RAM, out_sol on words 0,20,...,180, out_eof on word 199, done one cycle later.
REQ-034 out_ready pattern 1,0,0,1 repeating -> same 200-word sequence, out_data stable during stalls, mem_rd_en never with 2 credits used.
REQ-035 start pulsed again at word 50 -> ignored; exactly 200 words, one done.
REQ-036 reset_n low at word 120, then start -> no done from aborted frame, new frame begins at address 0 with out_sol.
REQ-037 FRAME_FETCH_LOOP_EN defined, out_ready=1 -> words 0..199,0..199 back-to-back, done pulsed after each eof, busy never falls.
REQ-038 WORDS_PER_LINE=1, LINES_PER_FRAME=1 -> single word with out_sol=out_eof=1, then done.
